// File: rtl/denorm_shift_pipe.sv
// Two-stage elastic right-shifter: stage 1 shifts by the coarse count bits,
// stage 2 by the fine count LSBs, both collecting a sticky OR of discarded bits.
module denorm_shift_pipe #(
  parameter int width = 16,
  parameter int split = 2,
  localparam int cw = $clog2(width) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] A_i,
  input  logic [cw-1:0]    cnt_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [width-1:0] Z_o,
  output logic             sticky_o
);

  // Returns {a >> amt, OR of the bits shifted out}; amounts >= width flush everything.
  function automatic logic [width:0] shr_sticky(input logic [width-1:0] a,
                                                input logic [cw-1:0]    amt);
    logic [2*width-1:0] ext;
    logic [width:0]     r;
    ext = {a, {width{1'b0}}} >> amt;
    if (int'(amt) >= width) r = {{width{1'b0}}, |a};
    else                    r = {ext[2*width-1:width], |ext[width-1:0]};
    return r;
  endfunction

  logic             s1_valid;
  logic [width-1:0] a1;
  logic             s1_sticky;
  logic [split-1:0] c1;

  logic             s2_ready;
  logic             in_fire;
  logic             s1_fire;
  logic [cw-1:0]    coarse_amt;
  logic [width:0]   coarse_res;
  logic [width:0]   fine_res;

  // Handshake: a beat moves across any boundary only on a clock edge where the
  // sender's valid and the receiver's ready are both high; ready never looks at
  // the incoming valid, and a stage with valid high holds its data until it fires.
  always_comb begin
    s2_ready   = ~valid_o | ready_i;
    ready_o    = ~s1_valid | s2_ready;
    in_fire    = valid_i & ready_o;
    s1_fire    = s1_valid & s2_ready;
    coarse_amt = {cnt_i[cw-1:split], {split{1'b0}}};
    coarse_res = shr_sticky(A_i, coarse_amt);
    fine_res   = shr_sticky(a1, {{(cw-split){1'b0}}, c1});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      a1        <= '0;
      s1_sticky <= 1'b0;
      c1        <= '0;
      valid_o   <= 1'b0;
      Z_o       <= '0;
      sticky_o  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid  <= 1'b1;
        a1        <= coarse_res[width:1];
        s1_sticky <= coarse_res[0];
        c1        <= cnt_i[split-1:0];
      end else if (s1_fire) begin
        s1_valid  <= 1'b0;
      end

      if (s1_fire) begin
        valid_o  <= 1'b1;
        Z_o      <= fine_res[width:1];
        sticky_o <= s1_sticky | fine_res[0];
      end else if (ready_i) begin
        valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_denorm_shift_pipe.sv
// Bench for denorm_shift_pipe: vector table, hand-written flow-control and reset
// sequences, and a randomized run scored against a plain-arithmetic model.
module tb_denorm_shift_pipe;
  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  a;
  logic [CW-1:0] cnt;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  z;
  logic          sticky;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [W:0] exp_q[$];
  bit mon_on    = 1'b0;
  bit rand_done = 1'b0;

  typedef struct {
    logic [W-1:0]  av;
    logic [CW-1:0] cv;
    logic [W-1:0]  ez;
    logic          es;
  } vec_t;
  vec_t vecs[11];

  denorm_shift_pipe #(.width(W), .split(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .A_i(a), .cnt_i(cnt), .valid_o(valid_o), .ready_i(ready_i),
    .Z_o(z), .sticky_o(sticky)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A >> n with sticky = |(A & ((1<<n)-1)), in 64-bit arithmetic
  function automatic logic [W:0] ref_model(input logic [W-1:0] av, input int sh);
    logic [63:0] wide;
    logic [63:0] mask;
    wide = {48'd0, av};
    mask = (64'd1 << sh) - 64'd1;
    return {W'(wide >> sh), |(wide & mask)};
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / output monitor
  logic [W:0] held;
  bit stalled = 1'b0;
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (stalled) begin
        check_bit("hold_valid", valid_o, 1'b1);
        check("hold_data", {z, sticky}, held);
      end
      if (ready_i) check_bit("ready_when_ready_i", ready_o, 1'b1);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", {z, sticky});
        end else begin
          check("data", {z, sticky}, exp_q.pop_front());
        end
      end
      stalled = valid_o && !ready_i;
      held    = {z, sticky};
    end else begin
      stalled = 1'b0;
    end
  end

  // driver: present a beat, wait for acceptance, record its expected result
  task automatic send(input logic [W-1:0] av, input logic [CW-1:0] cv, input logic [W:0] ev);
    logic r0;
    int   n;
    n = 0;
    valid_i = 1'b0;
    a = av;
    cnt = cv;
    #1;
    r0 = ready_o;
    valid_i = 1'b1;
    #1;
    check_bit("ready_indep_of_valid", ready_o, r0);
    @(negedge clk);
    while (!ready_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready_o=0 expected 1 within 1000 cycles");
      valid_i = 1'b0;
    end else begin
      exp_q.push_back(ev);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int c0;
    vecs[0]  = '{16'h8001, 5'd1,  16'h4000, 1'b1};
    vecs[1]  = '{16'hF000, 5'd12, 16'h000F, 1'b0};
    vecs[2]  = '{16'hA5A5, 5'd0,  16'hA5A5, 1'b0};
    vecs[3]  = '{16'hA5A5, 5'd16, 16'h0000, 1'b1};
    vecs[4]  = '{16'hFFFF, 5'd31, 16'h0000, 1'b1};
    vecs[5]  = '{16'h0000, 5'd7,  16'h0000, 1'b0};
    vecs[6]  = '{16'h0003, 5'd1,  16'h0001, 1'b1};
    vecs[7]  = '{16'h8000, 5'd15, 16'h0001, 1'b0};
    vecs[8]  = '{16'h00FF, 5'd4,  16'h000F, 1'b1};
    vecs[9]  = '{16'h1234, 5'd3,  16'h0246, 1'b1};
    vecs[10] = '{16'h0010, 5'd4,  16'h0001, 1'b0};

    // reset
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; a = '0; cnt = '0;
    #2;
    check_bit("rst_valid_o", valid_o, 1'b0);
    check("rst_z", {1'b0, z}, '0);
    check_bit("rst_sticky", sticky, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    check_bit("ready_after_reset", ready_o, 1'b1);
    @(posedge clk);
    #1;

    // vector table, back to back
    foreach (vecs[i]) send(vecs[i].av, vecs[i].cv, {vecs[i].ez, vecs[i].es});
    idle();
    drain(20);

    // two-cycle latency
    send(16'h8001, 5'd1, {16'h4000, 1'b1});
    idle();
    @(negedge clk);
    check_bit("latency_cycle1", valid_o, 1'b0);
    @(negedge clk);
    check_bit("latency_cycle2", valid_o, 1'b1);
    drain(10);

    // count sweep at full throughput
    c0 = cyc;
    for (int i = 0; i < 32; i++) send(16'hA5A5, CW'(i), ref_model(16'hA5A5, i));
    idle();
    drain(60);
    check("sweep_cycles", 17'(cyc - c0), 17'd34);

    // backpressure: two beats fill the pipe, the third must wait
    ready_i = 1'b0;
    send(16'h1111, 5'd0, {16'h1111, 1'b0});
    send(16'hF00F, 5'd4, {16'h0F00, 1'b1});
    a = 16'hC003; cnt = 5'd2; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("bp_ready_low", ready_o, 1'b0);
      check_bit("bp_valid_held", valid_o, 1'b1);
      @(posedge clk);
      #1;
      a = 16'($urandom);
      cnt = CW'($urandom_range(0, 31));
    end
    ready_i = 1'b1;
    send(16'hC003, 5'd2, {16'h3000, 1'b1});
    idle();
    drain(10);

    // randomized valid/ready traffic
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [W-1:0]  av;
          logic [CW-1:0] cv;
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          av = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
          cv = CW'($urandom_range(0, 31));
          send(av, cv, ref_model(av, int'(cv)));
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1'b1;
    drain(100);

    // reset with two beats in flight
    ready_i = 1'b0;
    send(16'h1234, 5'd3, {16'h0246, 1'b1});
    send(16'hFFFF, 5'd8, {16'h00FF, 1'b1});
    idle();
    @(negedge clk);
    check_bit("pre_rst_valid", valid_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_bit("rst_async_valid", valid_o, 1'b0);
    check("rst_async_z", {1'b0, z}, '0);
    check_bit("rst_async_sticky", sticky, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("no_stale_output", valid_o, 1'b0);
    end
    @(posedge clk);
    #1;
    send(16'h0003, 5'd1, {16'h0001, 1'b1});
    idle();
    drain(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
